// File: rtl/ls_pkg.sv
// ls_pkg: shared state encoding and default instruction width for the load/store sequencer
package ls_pkg;
  localparam int LS_INSTR_W = 32;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RETIRE, DRAIN} ls_seq_state_t;
endpackage

// File: rtl/ls_seq_watchdog.sv
// ls_seq_watchdog: per-state cycle counter with a sticky expiry error
module ls_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_active,
  input  logic i_clear,
  output logic o_expire,
  output logic o_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign o_expire = i_active && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign o_err = r_err;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (i_clear || !i_active) ? '0 : r_cnt + 1'b1;
      r_err <= r_err || o_expire;
    end
  end
endmodule

// File: rtl/ls_sequencer.sv
// ls_sequencer: issues one load/store at a time from the queue head to memory and retires it.
// Define LS_SEQ_TIMEOUT_EN to add a watchdog that aborts stalled ISSUE/WAIT/DRAIN states.
module ls_sequencer import ls_pkg::*; #(
  parameter int INSTR_W        = LS_INSTR_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               q_empty,
  input  logic [INSTR_W-1:0] q_head_instr,
  output logic               q_pop,
  input  logic               flush_valid,
  input  logic [INSTR_W-1:0] flush_instr,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_instr,
  input  logic               mem_ack,
  input  logic               mem_done,
  output logic               done_valid,
  output logic [INSTR_W-1:0] done_instr,
  output logic               busy
`ifdef LS_SEQ_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);
  ls_seq_state_t      r_state, w_next;
  logic [INSTR_W-1:0] r_cur;
  logic               w_match_head, w_match_cur, w_expire;
  assign w_match_head = flush_valid && flush_instr == q_head_instr;
  assign w_match_cur  = flush_valid && flush_instr == r_cur;
`ifdef LS_SEQ_TIMEOUT_EN
  ls_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .i_active (r_state == ISSUE || r_state == WAIT || r_state == DRAIN),
    .i_clear  (w_next != r_state),
    .o_expire (w_expire),
    .o_err    (timeout_err)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES[0];
  assign w_expire = 1'b0;
`endif
  // A flushed request that completes in the same cycle it is flushed needs no drain.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (!q_empty && !w_match_head) ? ISSUE : IDLE;
      ISSUE:   w_next = mem_ack ? (w_match_cur ? (mem_done ? IDLE : DRAIN) : (mem_done ? RETIRE : WAIT))
                                : (w_match_cur ? IDLE : ISSUE);
      WAIT:    w_next = w_match_cur ? (mem_done ? IDLE : DRAIN) : (mem_done ? RETIRE : WAIT);
      RETIRE:  w_next = IDLE;
      DRAIN:   w_next = mem_done ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
    if (w_expire) w_next = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= '0;
    end else begin
      r_state <= w_next;
      r_cur   <= (r_state == IDLE && w_next == ISSUE) ? q_head_instr : r_cur;
    end
  end
  assign mem_req    = r_state == ISSUE;
  assign mem_instr  = mem_req ? r_cur : '0;
  assign q_pop      = r_state == RETIRE;
  assign done_valid = q_pop;
  assign done_instr = q_pop ? r_cur : '0;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_ls_sequencer.sv
// tb_ls_sequencer: directed scenarios checked against a transaction-level model every cycle
module tb_ls_sequencer;
  logic        clock = 0, reset = 1, q_empty = 1, flush_valid = 0, mem_ack = 0, mem_done = 0;
  logic [31:0] q_head_instr = 0, flush_instr = 0;
  logic        q_pop, mem_req, done_valid, busy;
  logic [31:0] mem_instr, done_instr;
`ifdef LS_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif
  int          errors = 0, checks = 0, pops = 0, dones = 0, p0, d0;
  logic [31:0] last_done = 0;
  logic        model_en = 0;
  logic        m_hold = 0, m_acc = 0, m_fin = 0, m_dead = 0;
  logic [31:0] m_instr = 0;

  ls_sequencer #(.INSTR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .q_empty(q_empty), .q_head_instr(q_head_instr), .q_pop(q_pop),
    .flush_valid(flush_valid), .flush_instr(flush_instr), .mem_req(mem_req), .mem_instr(mem_instr),
    .mem_ack(mem_ack), .mem_done(mem_done), .done_valid(done_valid), .done_instr(done_instr), .busy(busy)
`ifdef LS_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: holds at most one instruction and tracks accepted / completed / flushed flags.
  always @(posedge clock) begin
    if (reset) begin
      m_hold = 0; m_acc = 0; m_fin = 0; m_dead = 0; m_instr = 0;
    end else if (!m_hold) begin
      if (!q_empty && !(flush_valid && flush_instr == q_head_instr)) begin
        m_hold = 1; m_instr = q_head_instr; m_acc = 0; m_fin = 0; m_dead = 0;
      end
    end else if (m_fin) m_hold = 0;
    else if (!m_acc && !mem_ack) begin
      if (flush_valid && flush_instr == m_instr) m_hold = 0;
    end else begin
      if (!m_dead) m_dead = flush_valid && flush_instr == m_instr;
      m_acc = 1;
      if (mem_done) begin
        if (m_dead) m_hold = 0;
        else m_fin = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (q_pop) begin pops++; last_done = done_instr; end
    if (done_valid) dones++;
    if (model_en) begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_hold && !m_acc});
      chk("mem_instr", mem_instr, (m_hold && !m_acc) ? m_instr : 32'h0);
      chk("q_pop", {31'b0, q_pop}, {31'b0, m_hold && m_fin});
      chk("done_valid", {31'b0, done_valid}, {31'b0, m_hold && m_fin});
      chk("done_instr", done_instr, (m_hold && m_fin) ? m_instr : 32'h0);
      chk("busy", {31'b0, busy}, {31'b0, m_hold});
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic load(logic [31:0] v);
    q_empty = 0; q_head_instr = v;
  endtask

  initial begin
    cyc(2);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    reset = 0; model_en = 1;
    // ack with request, done two cycles later
    p0 = pops; d0 = dones;
    load(32'h0000_1234); cyc(1);
    mem_ack = 1; cyc(1);
    mem_ack = 0; cyc(1);
    mem_done = 1; cyc(1);
    mem_done = 0; q_empty = 1;
    chk("t1_pop_now", {31'b0, q_pop}, 32'h1);
    cyc(3);
    chk("t1_pops", pops - p0, 1);
    chk("t1_dones", dones - d0, 1);
    chk("t1_done_instr", last_done, 32'h0000_1234);
    // minimum latency: ack and done during the first ISSUE cycle
    load(32'h55); mem_ack = 1; mem_done = 1; cyc(1);
    chk("lat_issue_nopop", {31'b0, q_pop}, 32'h0);
    cyc(1);
    chk("lat_pop_cycle3", {31'b0, q_pop}, 32'h1);
    flush_valid = 1; flush_instr = 32'h55;
    mem_ack = 0; mem_done = 0; q_empty = 1; cyc(1);
    flush_valid = 0;
    chk("lat_retire_flush_ignored", last_done, 32'h55);
    cyc(2);
    // ack delayed five cycles
    p0 = pops;
    load(32'h77); cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_stable", {31'b0, mem_req}, 32'h1);
      chk("t3_instr_stable", mem_instr, 32'h77);
      cyc(1);
    end
    mem_ack = 1; mem_done = 1; cyc(1);
    mem_ack = 0; mem_done = 0; q_empty = 1; cyc(3);
    chk("t3_pops", pops - p0, 1);
    // flush matching the head while idle blocks the latch
    load(32'hCD); flush_valid = 1; flush_instr = 32'hCD; cyc(2);
    chk("idle_flush_busy", {31'b0, busy}, 32'h0);
    flush_valid = 0; cyc(1);
    chk("idle_release_instr", mem_instr, 32'hCD);
    mem_ack = 1; mem_done = 1; cyc(1);
    mem_ack = 0; mem_done = 0; q_empty = 1; cyc(2);
    // flush in ISSUE before ack
    p0 = pops; d0 = dones;
    load(32'hAB); cyc(1);
    flush_valid = 1; flush_instr = 32'hAB; q_empty = 1; cyc(1);
    flush_valid = 0;
    chk("t4_req_dropped", {31'b0, mem_req}, 32'h0);
    chk("t4_idle", {31'b0, busy}, 32'h0);
    cyc(3);
    chk("t4_pops", pops - p0, 0);
    chk("t4_dones", dones - d0, 0);
    // flush in WAIT, done three cycles later
    load(32'hAB); cyc(1);
    mem_ack = 1; cyc(1);
    mem_ack = 0; flush_valid = 1; flush_instr = 32'hAB; q_empty = 1; cyc(1);
    flush_valid = 0;
    chk("t5_drain_busy", {31'b0, busy}, 32'h1);
    chk("t5_drain_noreq", {31'b0, mem_req}, 32'h0);
    cyc(2);
    mem_done = 1; cyc(1);
    mem_done = 0;
    chk("t5_idle", {31'b0, busy}, 32'h0);
    cyc(2);
    chk("t5_pops", pops - p0, 0);
    chk("t5_dones", dones - d0, 0);
    // reset mid-transaction, late done ignored
    load(32'h99); cyc(1);
    mem_ack = 1; cyc(1);
    mem_ack = 0; reset = 1; cyc(1);
    reset = 0; q_empty = 1;
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_req", {31'b0, mem_req}, 32'h0);
    chk("t6_instr", mem_instr, 32'h0);
    chk("t6_done_instr", done_instr, 32'h0);
    cyc(2);
    mem_done = 1; cyc(1);
    mem_done = 0; cyc(2);
    chk("t6_pops", pops - p0, 0);
    chk("t6_busy_late", {31'b0, busy}, 32'h0);
`ifdef LS_SEQ_TIMEOUT_EN
    model_en = 0; p0 = pops;
    load(32'h42); cyc(1);
    q_empty = 1; cyc(7);
    chk("to_still_issue", {31'b0, mem_req}, 32'h1);
    chk("to_no_err_yet", {31'b0, timeout_err}, 32'h0);
    cyc(1);
    chk("to_err", {31'b0, timeout_err}, 32'h1);
    chk("to_idle", {31'b0, busy}, 32'h0);
    cyc(3);
    chk("to_sticky", {31'b0, timeout_err}, 32'h1);
    chk("to_no_pop", pops - p0, 0);
    reset = 1; cyc(1);
    reset = 0;
    chk("to_cleared", {31'b0, timeout_err}, 32'h0);
`endif
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ls_sequencer.md
LS_SEQUENCER -- requirements
Module: ls_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit (used only under LS_SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port q_empty  in  1  load/store queue empty flag.
REQ-006 SHALL have port q_head_instr  in  INSTR_W  current queue head instruction.
REQ-007 SHALL have port q_pop  out  1  one-cycle pop pulse to the queue.
REQ-008 SHALL have port flush_valid  in  1  flush request qualifier.
REQ-009 SHALL have port flush_instr  in  INSTR_W  instruction tag being flushed.
REQ-010 SHALL have port mem_req  out  1  memory request valid.
REQ-011 SHALL have port mem_instr  out  INSTR_W  instruction presented to memory.
REQ-012 SHALL have port mem_ack  in  1  memory accepted request this cycle.
REQ-013 SHALL have port mem_done  in  1  memory completed outstanding request.
REQ-014 SHALL have port done_valid  out  1  one-cycle retire notification.
REQ-015 SHALL have port done_instr  out  INSTR_W  retired instruction.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port timeout_err  out  1  sticky watchdog error (present only under LS_SEQ_TIMEOUT_EN).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RETIRE, DRAIN.
REQ-019 In IDLE with q_empty=0 and no flush matching q_head_instr, SHALL latch q_head_instr into cur_instr and move to ISSUE next cycle.
REQ-020 In IDLE with flush_valid=1 and flush_instr==q_head_instr, SHALL stay in IDLE and not latch.
REQ-021 In ISSUE, mem_req SHALL be 1 and mem_instr SHALL equal cur_instr, both stable until mem_ack.
REQ-022 In ISSUE with mem_ack=1, SHALL move to WAIT; mem_done in the same cycle as mem_ack SHALL move directly to RETIRE.
REQ-023 In ISSUE with matching flush and mem_ack=0, SHALL drop mem_req next cycle and return to IDLE without q_pop or done_valid.
REQ-024 In ISSUE with matching flush and mem_ack=1 in the same cycle, SHALL treat request as accepted and go to DRAIN.
REQ-025 In WAIT, mem_done=1 SHALL move to RETIRE; matching flush SHALL move to DRAIN.
REQ-026 In RETIRE (exactly one cycle), q_pop=1, done_valid=1, done_instr=cur_instr, then IDLE.
REQ-027 In DRAIN, SHALL wait for mem_done, then IDLE with no q_pop and no done_valid (queue removes flushed entry itself).
REQ-028 Flush in RETIRE SHALL be ignored; retirement completes.
REQ-029 Minimum latency queue-nonempty to q_pop SHALL be 3 cycles (IDLE latch, ISSUE with ack+done, RETIRE).
REQ-030 At most one request SHALL be outstanding; mem_req SHALL never be high outside ISSUE.

Reset
REQ-031 reset=1 SHALL force IDLE, cur_instr=0, q_pop=0, mem_req=0, mem_instr=0, done_valid=0, done_instr=0, busy=0, timeout_err=0, watchdog=0, overriding all inputs including mid-transaction.
REQ-032 A mem_done arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-033 Macro LS_SEQ_TIMEOUT_EN SHALL, when defined, enable a watchdog counting cycles in ISSUE/WAIT/DRAIN, clearing on state entry; at TIMEOUT_CYCLES SHALL set timeout_err (sticky until reset) and force IDLE without pop.
REQ-034 Without LS_SEQ_TIMEOUT_EN, SHALL have no counter and no timeout_err port; waits are unbounded.

Structure
REQ-035 Shared package ls_pkg SHALL hold the state enum ls_seq_state_t and INSTR_W default constant.
REQ-036 Sub-module ls_seq_watchdog SHALL hold the counter, instantiated only under LS_SEQ_TIMEOUT_EN.

Verification
REQ-037 Queue head 0x0000_1234, mem_ack same cycle as mem_req, mem_done 2 cycles later -> q_pop and done_valid for one cycle, done_instr=0x0000_1234.
REQ-038 mem_ack delayed 5 cycles -> mem_req and mem_instr stable for all 5 cycles, one q_pop total.
REQ-039 Flush of 0xAB in ISSUE before ack -> mem_req low next cycle, IDLE, no q_pop/done_valid.
REQ-040 Flush of 0xAB in WAIT, mem_done 3 cycles later -> DRAIN then IDLE, no done_valid.
REQ-041 reset asserted in WAIT -> next cycle all outputs 0; later mem_done produces no pop.
REQ-042 With LS_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack -> timeout_err=1 after 8 cycles, IDLE, held until reset.
